sha256_bit_sequencer: RTL and testbench

Timing master for the bit-serial SHA-256 round datapath. Generates the bit clock strobe `bclk`, the per-word bit index `counter` and the round index consumed by every serial element (shift registers, rotators, serial adders), and runs one 64-round compression per `start` request with a busy/done handshake. It sits between the message-block loader and the round datapath, and is the only source of `bclk` and `counter` in the SHA-256 core.

---
 rtl/sha256_bit_sequencer.sv | 90 +++++++++
 tb/tb_sha256_bit_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sha256_bit_sequencer.sv
// sha256_bit_sequencer: bit clock, bit index and round index generator for the bit-serial SHA-256 round datapath.
module sha256_bit_sequencer #(
  parameter int W_WORD     = 32,
  parameter int ROUNDS     = 64,
  parameter int MSG_ROUNDS = 16,
  parameter int DIV        = 2,
  localparam int CW = $clog2(W_WORD),
  localparam int RW = $clog2(ROUNDS),
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          bclk,
  output logic [CW-1:0] counter,
  output logic [RW-1:0] round,
  output logic          msg_sel,
  output logic          last_bit,
  output logic          word_strobe
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state, state_nx;
  logic [DW-1:0] div_q, div_nx;
  logic [CW-1:0] counter_nx;
  logic [RW-1:0] round_nx;
  logic          bclk_nx, done_nx, ws_nx, tick;
  assign msg_sel  = 32'(round) < MSG_ROUNDS;
  assign last_bit = counter == CW'(W_WORD - 1);
  assign tick     = div_q == DW'(DIV - 1);
  // indices only advance on the falling (play) edge so they stay stable across a full bit period
  always_comb begin
    state_nx   = state;
    div_nx     = div_q;
    bclk_nx    = bclk;
    counter_nx = counter;
    round_nx   = round;
    done_nx    = 1'b0;
    ws_nx      = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nx   = RUN;
        div_nx     = '0;
        counter_nx = '0;
        round_nx   = '0;
        bclk_nx    = 1'b0;
      end
      RUN: begin
        div_nx = tick ? '0 : div_q + DW'(1);
        if (tick) begin
          bclk_nx = ~bclk;
          if (bclk) begin
            counter_nx = last_bit ? '0 : counter + CW'(1);
            if (last_bit) begin
              ws_nx = 1'b1;
              if (round != RW'(ROUNDS - 1)) round_nx = round + RW'(1);
              else begin
                state_nx = DONE;
                done_nx  = 1'b1;
              end
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div_q       <= '0;
      bclk        <= 1'b0;
      counter     <= '0;
      round       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      word_strobe <= 1'b0;
    end else begin
      state       <= state_nx;
      div_q       <= div_nx;
      bclk        <= bclk_nx;
      counter     <= counter_nx;
      round       <= round_nx;
      busy        <= state_nx != IDLE;
      done        <= done_nx;
      word_strobe <= ws_nx;
    end
  end
endmodule

// File: tb/tb_sha256_bit_sequencer.sv
// tb_sha256_bit_sequencer: randomized start/reset stimulus against a timing model derived from edge arithmetic.
module tb_sha256_bit_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic b_start = 1'b0, s_start = 1'b0;
  logic b_busy, b_done, b_bclk, b_msg, b_last, b_ws;
  logic s_busy, s_done, s_bclk, s_msg, s_last, s_ws;
  logic [4:0] b_counter, s_counter;
  logic [5:0] b_round;
  logic [0:0] s_round;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sha256_bit_sequencer dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .bclk(b_bclk), .counter(b_counter), .round(b_round), .msg_sel(b_msg),
    .last_bit(b_last), .word_strobe(b_ws)
  );

  sha256_bit_sequencer #(.ROUNDS(2), .DIV(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
    .bclk(s_bclk), .counter(s_counter), .round(s_round), .msg_sel(s_msg),
    .last_bit(s_last), .word_strobe(s_ws)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) s_start = v;
    else b_start = v;
  endtask

  task automatic check_idle(input bit sel, input string tag);
    chk({tag, "_busy"}, sel ? s_busy : b_busy, 0);
    chk({tag, "_done"}, sel ? s_done : b_done, 0);
    chk({tag, "_bclk"}, sel ? s_bclk : b_bclk, 0);
    chk({tag, "_ws"}, sel ? s_ws : b_ws, 0);
  endtask

  // Expected values come from edge arithmetic: bit n spans edges [2*d*n, 2*d*(n+1)).
  task automatic run(input bit sel, input int d, input int r, input bit noise);
    int total, bitn, rises, strobes, ec, er, eb, ebusy, edone, ews, oc, orr;
    logic ob, prev_b;
    total = r * 32 * 2 * d;
    rises = 0;
    strobes = 0;
    prev_b = 1'b0;
    set_start(sel, 1'b1);
    for (int e = 0; e <= total + 1; e++) begin
      @(negedge clk);
      if (e < total) begin
        bitn = e / (2 * d);
        ec = bitn % 32; er = bitn / 32; eb = (e / d) % 2;
        ebusy = 1; edone = 0; ews = (e > 0 && e % (64 * d) == 0) ? 1 : 0;
      end else begin
        ec = 0; er = r - 1; eb = 0;
        ebusy = (e == total) ? 1 : 0; edone = ebusy; ews = ebusy;
      end
      ob  = sel ? s_bclk : b_bclk;
      oc  = sel ? int'(s_counter) : int'(b_counter);
      orr = sel ? int'(s_round) : int'(b_round);
      chk("bclk", ob, eb);
      chk("counter", oc, ec);
      chk("round", orr, er);
      chk("busy", sel ? s_busy : b_busy, ebusy);
      chk("done", sel ? s_done : b_done, edone);
      chk("word_strobe", sel ? s_ws : b_ws, ews);
      chk("msg_sel", sel ? s_msg : b_msg, er < 16 ? 1 : 0);
      chk("last_bit", sel ? s_last : b_last, ec == 31 ? 1 : 0);
      if (ob && !prev_b) rises++;
      prev_b = ob;
      if (sel ? s_ws : b_ws) strobes++;
      if (e <= total)
        set_start(sel, noise && ($urandom_range(0, 7) == 0 || e + 1 == 100 || e + 1 == total));
      else
        set_start(sel, 1'b0);
    end
    chk("bclk_rises", rises, r * 32);
    chk("strobe_count", strobes, r);
  endtask

  initial begin
    int gap, target;
    repeat (3) @(negedge clk);
    check_idle(0, "rst");
    chk("rst_counter", int'(b_counter), 0);
    chk("rst_round", int'(b_round), 0);
    check_idle(1, "rst_s");
    rst_n = 1'b1;
    gap = $urandom_range(3, 12);
    repeat (gap) begin
      @(negedge clk);
      check_idle(0, "idle");
      chk("idle_counter", int'(b_counter), 0);
      chk("idle_round", int'(b_round), 0);
    end

    run(0, 2, 64, 1);
    run(0, 2, 64, 1);
    repeat (4) begin
      @(negedge clk);
      check_idle(0, "post");
    end

    b_start = 1'b1;
    target = (20 * 32 + 7) * 4 + $urandom_range(0, 3);
    for (int e = 0; e <= target; e++) begin
      @(negedge clk);
      b_start = 1'b0;
    end
    chk("pre_rst_counter", int'(b_counter), 7);
    chk("pre_rst_round", int'(b_round), 20);
    chk("pre_rst_busy", b_busy, 1);
    rst_n = 1'b0;
    #1;
    check_idle(0, "midrst");
    chk("midrst_counter", int'(b_counter), 0);
    chk("midrst_round", int'(b_round), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check_idle(0, "after_rst");
    end

    run(0, 2, 64, 0);
    @(negedge clk);
    run(1, 1, 2, 1);
    run(1, 1, 2, 0);
    repeat (3) begin
      @(negedge clk);
      check_idle(1, "s_post");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
